// File: rtl/wb_stage_pipe_if.sv
// MEM -> WB stage bus: the op presented by the MEM stage, its load data,
// and the ready back-pressure returned by the writeback stage.
interface wb_stage_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int JADDR_W = 10,
  parameter int RADDR_W = 5
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic               in_valid;
  logic               in_ready;
  logic [2:0]         regsel;
  logic [RADDR_W-1:0] dest;
  logic               reg_we;
  logic               hilo_we;
  logic [DATA_W-1:0]  alulo;
  logic [DATA_W-1:0]  aluhi;
  logic [DATA_W-1:0]  link;
  logic [JADDR_W-1:0] jaddr;
  logic [1:0]         ld_size;
  logic               ld_signed;
  logic [OFF_W-1:0]   ld_off;
  logic [DATA_W-1:0]  memdata;
  logic               mem_valid;

  modport master (
    output in_valid, regsel, dest, reg_we, hilo_we, alulo, aluhi, link,
           jaddr, ld_size, ld_signed, ld_off, memdata, mem_valid,
    input  in_ready
  );

  modport slave (
    input  in_valid, regsel, dest, reg_we, hilo_we, alulo, aluhi, link,
           jaddr, ld_size, ld_signed, ld_off, memdata, mem_valid,
    output in_ready
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// Registered MIPS writeback stage: source select, HI/LO ownership, sub-word
// load alignment, and a one-op stall while load data is outstanding.
module wb_stage_pipe #(
  parameter int DATA_W  = 32,
  parameter int JADDR_W = 10,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  wb_stage_pipe_if.slave     mem_if,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [DATA_W-1:0]  hi_q,
  output logic [DATA_W-1:0]  lo_q,
  output logic [CNT_W-1:0]   wb_count
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               rf_we_q, rf_we_d;
  logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
  logic [DATA_W-1:0]  hi_d, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RADDR_W-1:0] cap_dest_q, cap_dest_d;
  logic               cap_we_q, cap_we_d;
  logic [1:0]         cap_size_q, cap_size_d;
  logic               cap_signed_q, cap_signed_d;
  logic [OFF_W-1:0]   cap_off_q, cap_off_d;
  logic               accept_s;
  logic [DATA_W-1:0]  src_data_s;

  // Half-word loads drop offset bit 0, so the halfword is always 2-byte aligned.
  function automatic logic [DATA_W-1:0] fmt_load(
    input logic [1:0]        size,
    input logic              sgn,
    input logic [OFF_W-1:0]  off,
    input logic [DATA_W-1:0] data
  );
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] res;
    byte_v = data[{off, 3'b000} +: 8];
    half_v = data[{off[OFF_W-1:1], 4'b0000} +: 16];
    case (size)
      2'b01:   res = {{(DATA_W-16){sgn & half_v[15]}}, half_v};
      2'b10:   res = {{(DATA_W-8){sgn & byte_v[7]}}, byte_v};
      default: res = data;
    endcase
    return res;
  endfunction

  assign accept_s        = mem_if.in_valid & (state_q == RUN);
  assign mem_if.in_ready = (state_q == RUN);

  // HI/LO reads use the registered values, so an op that also writes HI/LO sees the old contents.
  always_comb begin
    case (mem_if.regsel)
      3'b000:  src_data_s = mem_if.alulo;
      3'b001:  src_data_s = hi_q;
      3'b010:  src_data_s = lo_q;
      3'b011:  src_data_s = fmt_load(mem_if.ld_size, mem_if.ld_signed, mem_if.ld_off, mem_if.memdata);
      3'b100:  src_data_s = mem_if.link;
      3'b111:  src_data_s = {{(DATA_W-JADDR_W){1'b0}}, mem_if.jaddr};
      default: src_data_s = {DATA_W{1'b0}};
    endcase
  end

  // Next-state and writeback decode.
  always_comb begin
    state_d      = state_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    cap_dest_d   = cap_dest_q;
    cap_we_d     = cap_we_q;
    cap_size_d   = cap_size_q;
    cap_signed_d = cap_signed_q;
    cap_off_d    = cap_off_q;
    case (state_q)
      RUN: begin
        if (accept_s) begin
          if (mem_if.hilo_we) begin
            hi_d = mem_if.aluhi;
            lo_d = mem_if.alulo;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
          if ((mem_if.regsel == 3'b011) && !mem_if.mem_valid) begin
            cap_dest_d   = mem_if.dest;
            cap_we_d     = mem_if.reg_we;
            cap_size_d   = mem_if.ld_size;
            cap_signed_d = mem_if.ld_signed;
            cap_off_d    = mem_if.ld_off;
            state_d      = WAIT_MEM;
          end else begin
            rf_waddr_d = mem_if.dest;
            rf_wdata_d = src_data_s;
            rf_we_d    = mem_if.reg_we & (mem_if.dest != {RADDR_W{1'b0}});
          end
        end else begin
          state_d = RUN;
        end
      end
      WAIT_MEM: begin
        if (mem_if.mem_valid) begin
          rf_waddr_d = cap_dest_q;
          rf_wdata_d = fmt_load(cap_size_q, cap_signed_q, cap_off_q, mem_if.memdata);
          rf_we_d    = cap_we_q & (cap_dest_q != {RADDR_W{1'b0}});
          state_d    = RUN;
        end else begin
          state_d = WAIT_MEM;
        end
      end
      default: state_d = RUN;
    endcase
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, rf_we_d};
  end

  // Pipeline, HI/LO and captured-load registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= {RADDR_W{1'b0}};
      rf_wdata_q   <= {DATA_W{1'b0}};
      hi_q         <= {DATA_W{1'b0}};
      lo_q         <= {DATA_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      cap_dest_q   <= {RADDR_W{1'b0}};
      cap_we_q     <= 1'b0;
      cap_size_q   <= 2'b00;
      cap_signed_q <= 1'b0;
      cap_off_q    <= {OFF_W{1'b0}};
    end else begin
      state_q      <= state_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      cap_dest_q   <= cap_dest_d;
      cap_we_q     <= cap_we_d;
      cap_size_q   <= cap_size_d;
      cap_signed_q <= cap_signed_d;
      cap_off_q    <= cap_off_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign wb_count = cnt_q;

endmodule
